ifu_fetch: RTL and testbench

Instruction fetch unit sitting directly upstream of the single-cycle RV32I execute core. It owns the architectural PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and holds the returned word on a valid/ready interface until the core retires it. On retirement it takes the core's computed next PC and starts the next fetch. Bus errors, timeouts and (optionally) misaligned PCs raise a sticky fetch fault.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_wait_timer.sv | 46 ++++
 rtl/ifu_fetch.sv | 150 +++++++++++++++
 tb/tb_ifu_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_VALID = 2'd2,
      ST_FAULT = 2'd3
   } ifu_state_e;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_BUS_ERR  = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;
   localparam logic [1:0] FC_MISALIGN = 2'd3;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

   // Wait-timer width; a zero timeout still needs a one-bit register.
   function automatic int unsigned timer_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/ifu_wait_timer.sv
// Saturating wait timer for the fetch FSM.
// Kept as a down-counter: it holds the number of WAIT cycles still allowed
// (TIMEOUT minus cycles elapsed) and stops at zero, so it can never wrap.
// expired fires in the WAIT cycle whose completion makes the elapsed count
// equal TIMEOUT, so the FSM leaves WAIT after exactly TIMEOUT idle cycles.
// With TIMEOUT = 0 expired is never asserted.
module ifu_wait_timer
   import ifu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = timer_width(TIMEOUT);
   localparam logic [W-1:0] LOAD = W'(TIMEOUT);

   logic [W-1:0] rem_q;
   logic [W-1:0] rem_d;

   // Reload on clear, otherwise count down while enabled and stop at zero.
   always_comb begin
      rem_d = rem_q;
      if (clr) begin
         rem_d = LOAD;
      end else if (en && (rem_q != '0)) begin
         rem_d = rem_q - 1'b1;
      end
   end

   // Remaining-cycle register, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q <= LOAD;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign expired = (TIMEOUT != 0) && en && !clr && (rem_q == W'(1));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// presents the returned word on a valid/ready interface to the execute core.
// Optional build macro: IFU_MISALIGN_CHK_EN enables the misaligned-PC fault.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_REQ   | request pc on imem, waiting for gnt
// ST_WAIT  | request granted, waiting for rvalid (timed)
// ST_VALID | inst/inst_pc held for the core until inst_ready
// ST_FAULT | sticky fault, no further requests until reset
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic [31:0] next_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc,
   output logic [1:0]  fault_cause
);

   ifu_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [1:0]  fault_cause_q, fault_cause_d;
   logic        live_q, live_d;
   logic        misaligned;
   logic        timer_clr;
   logic        timer_en;
   logic        timer_expired;

`ifdef IFU_MISALIGN_CHK_EN
   assign misaligned = (pc_q[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // live_q holds off the first request until the cycle after reset releases.
   assign live_d = 1'b1;

   ifu_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   // Next-state and datapath updates for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      fault_pc_d    = fault_pc_q;
      fault_cause_d = fault_cause_q;
      timer_clr     = 1'b0;
      timer_en      = 1'b0;
      case (state_q)
         ST_REQ: begin
            if (live_q) begin
               if (misaligned) begin
                  state_d       = ST_FAULT;
                  fault_pc_d    = pc_q;
                  fault_cause_d = FC_MISALIGN;
               end else if (imem_gnt) begin
                  state_d   = ST_WAIT;
                  timer_clr = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            timer_en = 1'b1;
            if (imem_rvalid && !imem_err) begin
               state_d   = ST_VALID;
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
            end else if (imem_rvalid) begin
               state_d       = ST_FAULT;
               fault_pc_d    = pc_q;
               fault_cause_d = FC_BUS_ERR;
            end else if (timer_expired) begin
               state_d       = ST_FAULT;
               fault_pc_d    = pc_q;
               fault_cause_d = FC_TIMEOUT;
            end
         end
         ST_VALID: begin
            if (inst_ready) begin
               state_d = ST_REQ;
               pc_d    = next_pc;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_PC;
         inst_q        <= '0;
         inst_pc_q     <= RESET_PC;
         fault_pc_q    <= '0;
         fault_cause_q <= FC_NONE;
         live_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         inst_pc_q     <= inst_pc_d;
         fault_pc_q    <= fault_pc_d;
         fault_cause_q <= fault_cause_d;
         live_q        <= live_d;
      end
   end

   assign imem_req    = live_q && (state_q == ST_REQ) && !misaligned;
   assign imem_addr   = pc_q;
   assign inst_valid  = (state_q == ST_VALID);
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign fetch_fault = (state_q == ST_FAULT);
   assign fault_pc    = fault_pc_q;
   assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table of fetch transactions plus hand-written fault,
// reset and timeout sequences. dut has TIMEOUT=4, dut0 has TIMEOUT=0 and
// shares all inputs with dut.
module tb_ifu_fetch;

   localparam logic [31:0] RPC = 32'h8000_0000;

   typedef struct {
      int          gnt_dly;
      int          rv_dly;
      int          rdy_dly;
      logic [31:0] pc;
      logic [31:0] rdata;
      logic [31:0] nxt;
   } vec_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'hdead_beef;
   logic        imem_err = 1'b0;
   logic        inst_ready = 1'b0;
   logic [31:0] next_pc = 32'h0;

   logic        imem_req, inst_valid, fetch_fault;
   logic [31:0] imem_addr, inst, inst_pc, fault_pc;
   logic [1:0]  fault_cause;

   logic        z_imem_req, z_inst_valid, z_fetch_fault;
   logic [31:0] z_imem_addr, z_inst, z_inst_pc, z_fault_pc;
   logic [1:0]  z_fault_cause;

   int   errors = 0;
   int   checks = 0;
   int   grants = 0;
   logic prev_valid = 1'b0;
   sb_t  sb_q[$];
   vec_t vecs[4];
   vec_t v;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(4)) dut (
      .clk (clk), .reset (reset),
      .imem_req (imem_req), .imem_addr (imem_addr), .imem_gnt (imem_gnt),
      .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata), .imem_err (imem_err),
      .inst_valid (inst_valid), .inst_ready (inst_ready), .inst (inst),
      .inst_pc (inst_pc), .next_pc (next_pc), .fetch_fault (fetch_fault),
      .fault_pc (fault_pc), .fault_cause (fault_cause)
   );

   ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(0)) dut0 (
      .clk (clk), .reset (reset),
      .imem_req (z_imem_req), .imem_addr (z_imem_addr), .imem_gnt (imem_gnt),
      .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata), .imem_err (imem_err),
      .inst_valid (z_inst_valid), .inst_ready (inst_ready), .inst (z_inst),
      .inst_pc (z_inst_pc), .next_pc (next_pc), .fetch_fault (z_fetch_fault),
      .fault_pc (z_fault_pc), .fault_cause (z_fault_cause)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic misal(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHK_EN
      return (a[1:0] != 2'b00);
`else
      return (a[1:0] == 2'b00) && 1'b0;
`endif
   endfunction

   // Accepted requests, counted on the edge that samples gnt.
   always @(posedge clk) begin
      if (imem_req && imem_gnt) grants <= grants + 1;
   end

   // Scoreboard: every rising inst_valid must match the oldest expected fetch.
   always @(negedge clk) begin
      if (inst_valid && !prev_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_valid", 32'(sb_q.size()), 32'd1);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("sb_inst", inst, e.inst);
            chk("sb_inst_pc", inst_pc, e.pc);
         end
      end
      prev_valid <= inst_valid;
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, imem_addr, RPC);
      chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
      chk({tag, "_inst"}, inst, 32'd0);
      chk({tag, "_inst_pc"}, inst_pc, RPC);
      chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
      chk({tag, "_fault_pc"}, fault_pc, 32'd0);
      chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
   endtask

   task automatic do_fetch(input vec_t t);
      int n;
      int g0;
      g0 = grants;
      n = 0;
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      chk("req_wait_bound", 32'(n < 20), 32'd1);
      chk("req_addr", imem_addr, t.pc);
      for (int i = 0; i < t.gnt_dly; i++) begin
         imem_gnt = 1'b0;
         step();
         chk("req_hold", 32'(imem_req), 32'd1);
         chk("addr_hold", imem_addr, t.pc);
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("wait_no_req", 32'(imem_req), 32'd0);
      for (int i = 1; i < t.rv_dly; i++) begin
         step();
         chk("wait_no_valid", 32'(inst_valid), 32'd0);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = t.rdata;
      imem_err    = 1'b0;
      sb_q.push_back('{inst: t.rdata, pc: t.pc});
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hdead_beef;
      chk("valid_rise", 32'(inst_valid), 32'd1);
      for (int i = 0; i < t.rdy_dly; i++) begin
         step();
         chk("valid_hold", 32'(inst_valid), 32'd1);
         chk("inst_hold", inst, t.rdata);
         chk("inst_pc_hold", inst_pc, t.pc);
      end
      inst_ready = 1'b1;
      next_pc    = t.nxt;
      step();
      inst_ready = 1'b0;
      next_pc    = 32'h0;
      chk("one_grant", 32'(grants - g0), 32'd1);
      chk("valid_drop", 32'(inst_valid), 32'd0);
      chk("next_req", 32'(imem_req), misal(t.nxt) ? 32'd0 : 32'd1);
      chk("next_addr", imem_addr, t.nxt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g0;
      vecs[0] = '{0, 1, 0, 32'h8000_0000, 32'h0010_0093, 32'h8000_0004};
      vecs[1] = '{3, 1, 5, 32'h8000_0004, 32'h0020_0113, 32'h8000_0008};
      vecs[2] = '{1, 3, 0, 32'h8000_0008, 32'h0030_8193, 32'h8000_0100};
      vecs[3] = '{0, 2, 2, 32'h8000_0100, 32'h0000_006f, 32'h8000_0010};

      // Reset state of both instances.
      step(); step(); step();
      chk_reset_vals("rst");
      chk("rst_z_req", 32'(z_imem_req), 32'd0);
      chk("rst_z_addr", z_imem_addr, RPC);
      chk("rst_z_inst", z_inst, 32'd0);
      chk("rst_z_inst_pc", z_inst_pc, RPC);
      chk("rst_z_fault_pc", z_fault_pc, 32'd0);
      chk("rst_z_cause", 32'(z_fault_cause), 32'd0);
      reset = 1'b1;
      step();
      chk("first_req", 32'(imem_req), 32'd1);

      for (int i = 0; i < 4; i++) do_fetch(vecs[i]);

      // Bus error at 8000_0010, then stray traffic must be ignored.
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_err    = 1'b1;
      step();
      imem_rvalid = 1'b0;
      imem_err    = 1'b0;
      chk("err_fault", 32'(fetch_fault), 32'd1);
      chk("err_cause", 32'(fault_cause), 32'd1);
      chk("err_fault_pc", fault_pc, 32'h8000_0010);
      g0 = grants;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("fault_no_req", 32'(imem_req), 32'd0);
         chk("fault_no_valid", 32'(inst_valid), 32'd0);
      end
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
      chk("fault_no_grant", 32'(grants - g0), 32'd0);

      // Reset clears the fault; then reset again while in WAIT.
      reset = 1'b0;
      step();
      chk_reset_vals("rst2");
      reset = 1'b1;
      step();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("rst_wait_in_wait", 32'(imem_req), 32'd0);
      reset = 1'b0;
      step();
      chk_reset_vals("rst3");
      reset       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hbad0_0001;
      step();
      chk("stale_req", 32'(imem_req), 32'd1);
      chk("stale_addr", imem_addr, RPC);
      step();
      imem_rvalid = 1'b0;
      chk("stale_dropped", 32'(inst_valid), 32'd0);
      chk("stale_req_hold", 32'(imem_req), 32'd1);

      // Fresh fetch from RESET_PC retiring to a misaligned next PC.
      v = '{0, 1, 0, RPC, 32'h0040_0213, 32'h8000_0002};
      do_fetch(v);
`ifdef IFU_MISALIGN_CHK_EN
      g0 = grants;
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      chk("mis_cause", 32'(fault_cause), 32'd3);
      chk("mis_fault_pc", fault_pc, 32'h8000_0002);
      chk("mis_no_req", 32'(imem_req), 32'd0);
      chk("mis_no_grant", 32'(grants - g0), 32'd0);
`else
      v = '{0, 1, 0, 32'h8000_0002, 32'h0050_0293, 32'h8000_0008};
      do_fetch(v);
      chk("mis_no_fault", 32'(fetch_fault), 32'd0);
`endif

      // Timeout: dut (TIMEOUT=4) faults after 4 WAIT cycles, dut0 waits on.
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk("to_req", 32'(imem_req), 32'd1);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_not_yet", 32'(fetch_fault), 32'd0);
         step();
      end
      chk("to_fault", 32'(fetch_fault), 32'd1);
      chk("to_cause", 32'(fault_cause), 32'd2);
      chk("to_fault_pc", fault_pc, RPC);
      chk("to_no_req", 32'(imem_req), 32'd0);
      for (int i = 0; i < 20; i++) step();
      chk("to0_no_fault", 32'(z_fetch_fault), 32'd0);
      chk("to0_no_req", 32'(z_imem_req), 32'd0);
      chk("to0_no_valid", 32'(z_inst_valid), 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0013;
      step();
      imem_rvalid = 1'b0;
      chk("to0_valid", 32'(z_inst_valid), 32'd1);
      chk("to0_inst", z_inst, 32'h0000_0013);
      chk("to0_inst_pc", z_inst_pc, RPC);
      chk("to_still_fault", 32'(fetch_fault), 32'd1);
      chk("to_no_valid", 32'(inst_valid), 32'd0);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
